// File: rtl/pruned_cnn_mac_accum_if.sv
// -----------------------------------------------------------------------------
// pruned_cnn_mac_accum_if
// Beat/result handshake bundle for the pruned CNN MAC accumulator stage.
//   in_valid / in_ready / in_data / in_last / bias : product beat stream
//   out_valid / out_ready / out_data / out_sat     : rounded result stream
// Modports:
//   master : the environment (drives beats, consumes results)
//   slave  : the accumulator stage itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface pruned_cnn_mac_accum_if #(
    parameter int IN_WIDTH   = 28,
    parameter int BIAS_WIDTH = 16,
    parameter int OUT_WIDTH  = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [IN_WIDTH-1:0]   in_data;
    logic                         in_last;
    logic signed [BIAS_WIDTH-1:0] bias;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_sat;

    modport master (
        output in_valid, in_data, in_last, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/pruned_cnn_mac_accum.sv
// -----------------------------------------------------------------------------
// pruned_cnn_mac_accum
// Accumulates signed multiplier products of one kernel window on top of a
// bias, then rounds (half toward +inf), arithmetic-shifts by FRAC_SHIFT and
// saturates to OUT_WIDTH. The result is held until the next stage accepts it.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset, overrides ce
//   ce          : clock enable; when low every register holds
//   bus         : pruned_cnn_mac_accum_if.slave (beat in, result out)
//   err_overrun : sticky, a window reached MAX_TAPS without in_last
//
// Optional build macro:
//   PRUNED_CNN_MAC_RELU_EN : negative rounded results are forced to 0
//                            (out_sat=0 in that case) before saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pruned_cnn_mac_accum #(
    parameter int IN_WIDTH   = 28,
    parameter int BIAS_WIDTH = 16,
    parameter int ACC_WIDTH  = 36,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 10,
    parameter int MAX_TAPS   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    pruned_cnn_mac_accum_if.slave bus,
    output logic                  err_overrun
);

    localparam int CNT_W  = $clog2(MAX_TAPS + 1);
    localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TAPS);

    // Rounding constant 2^(FRAC_SHIFT-1); no term when there is no shift.
    localparam logic signed [ACC_WIDTH:0] RND =
        (FRAC_SHIFT == 0) ? '0 : ({{ACC_WIDTH{1'b0}}, 1'b1} << RND_SH);

    // Output range limits expressed at the rounding width.
    localparam logic signed [ACC_WIDTH:0] OMAX =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OMIN =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    // One extra bit of headroom keeps acc + RND from wrapping before the shift.
    function automatic logic signed [ACC_WIDTH:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] a
    );
        logic signed [ACC_WIDTH:0] t;
        t = {a[ACC_WIDTH-1], a};
        t = t + RND;
        return t >>> FRAC_SHIFT;
    endfunction

    // Returns {sat_flag, clamped_value}.
    function automatic logic [OUT_WIDTH:0] saturate(
        input logic signed [ACC_WIDTH:0] r
    );
        logic [OUT_WIDTH:0] res;
        if (r > OMAX) begin
            res = {1'b1, 1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else if (r < OMIN) begin
            res = {1'b1, 1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end else begin
            res = {1'b0, r[OUT_WIDTH-1:0]};
        end
`ifdef PRUNED_CNN_MAC_RELU_EN
        if (r < 0) begin
            res = '0;
        end
`endif
        return res;
    endfunction

    logic [1:0]                   state_p0;
    logic signed [ACC_WIDTH-1:0]  acc_p0;
    logic [CNT_W-1:0]             cnt_p0;
    logic                         vld_p1;
    logic signed [OUT_WIDTH-1:0]  data_p1;
    logic                         sat_p1;

    logic                         accept;
    logic [CNT_W-1:0]             cnt_nxt;
    logic signed [ACC_WIDTH-1:0]  din_ext;
    logic signed [ACC_WIDTH-1:0]  bias_ext;

    assign bus.in_ready = (state_p0 == S_IDLE) || (state_p0 == S_ACCUM);
    assign accept       = bus.in_valid & bus.in_ready & ce;
    assign cnt_nxt      = cnt_p0 + CNT_W'(1);
    assign din_ext      = {{(ACC_WIDTH - IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
    assign bias_ext     = {{(ACC_WIDTH - BIAS_WIDTH){bus.bias[BIAS_WIDTH-1]}}, bus.bias};

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_sat   = sat_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0    <= S_IDLE;
            acc_p0      <= '0;
            cnt_p0      <= '0;
            vld_p1      <= 1'b0;
            data_p1     <= '0;
            sat_p1      <= 1'b0;
            err_overrun <= 1'b0;
        end else if (ce) begin
            case (state_p0)
                // p0: accumulate beats of the current window
                S_IDLE: begin
                    if (accept) begin
                        acc_p0 <= bias_ext + din_ext;
                        cnt_p0 <= CNT_W'(1);
                        if (bus.in_last || (MAX_TAPS == 1)) begin
                            state_p0 <= S_ROUND;
                            if (!bus.in_last) begin
                                err_overrun <= 1'b1;
                            end
                        end else begin
                            state_p0 <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc_p0 <= acc_p0 + din_ext;
                        cnt_p0 <= cnt_nxt;
                        if (bus.in_last) begin
                            state_p0 <= S_ROUND;
                        end else if (cnt_nxt == MAX_CNT) begin
                            // Force the window closed so a missing in_last cannot wedge the stage.
                            state_p0    <= S_ROUND;
                            err_overrun <= 1'b1;
                        end
                    end
                end
                // p1: round, shift, saturate into the output register
                S_ROUND: begin
                    {sat_p1, data_p1} <= saturate(round_shift(acc_p0));
                    vld_p1   <= 1'b1;
                    state_p0 <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        vld_p1   <= 1'b0;
                        acc_p0   <= '0;
                        cnt_p0   <= '0;
                        state_p0 <= S_IDLE;
                    end
                end
                default: state_p0 <= S_IDLE;
            endcase
        end
    end

endmodule
